product_lsb_collector: RTL and testbench

//  Receive end of the accumulator's serial LSB stream in the 16x9 sequential multiplier.
//  - Samples the accumulator bit-0 output once per shift step and rebuilds the low product bits.
//  - When the multiply finishes, joins the accumulator's upper bits with those low bits.
//  - Presents the full product on a valid/ready handshake.
//  - Sits between the accumulator/controller and the product consumer.

---
 rtl/product_lsb_collector_pkg.sv | 20 ++
 rtl/product_lsb_collector_lsb_shift_reg.sv | 34 +++
 rtl/product_lsb_collector.sv | 124 ++++++++++++
 tb/tb_product_lsb_collector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_lsb_collector_pkg.sv
// Shared definitions for the 16x9 sequential multiplier's product collector.
// - Product field widths: the accumulator's upper field, the serial low bits,
//   and the assembled product.
// - Width of the shift-step counter.
// - State encoding used by the collector FSM.
package product_lsb_collector_pkg;

  localparam int MUL_ACC_W  = 17;
  localparam int MUL_LSB_W  = 8;
  localparam int MUL_PROD_W = MUL_ACC_W + MUL_LSB_W;
  localparam int MUL_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_FIN = 2'd2,
    ST_HOLD     = 2'd3
  } coll_state_t;

endpackage

// File: rtl/product_lsb_collector_lsb_shift_reg.sv
// lsb_shift_reg: serial-in, parallel-out register for the product LSBs.
// New bits enter at the MSB and the word shifts right, so the first bit
// shifted in ends up at bit 0 after W shifts.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear (takes priority over en)
//   en    in  shift enable
//   d     in  serial data bit
//   q     out parallel register contents
module lsb_shift_reg
  import product_lsb_collector_pkg::*;
#(
  parameter int W = MUL_LSB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {d, q[W-1:1]};
    end
  end

endmodule

// File: rtl/product_lsb_collector.sv
// product_lsb_collector: receive end of the accumulator's serial LSB stream.
// Samples ACC[0] once per shift step to rebuild the low product bits, then
// joins them with the accumulator's final upper field and offers the full
// product on a valid/ready handshake.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   start     in  one-cycle pulse: a new multiply begins
//   shift_en  in  accumulator shift step this cycle; sample d_in
//   d_in      in  serial LSB from the accumulator (ACC[0])
//   acc_final in  acc_in holds the final upper product this cycle
//                 (named acc_final because "final" is a reserved word)
//   acc_in    in  accumulator contents
//   p_out     out assembled product {upper, lsb}
//   p_valid   out p_out valid
//   p_ready   in  consumer accepts p_out
//   busy      out high while collecting or waiting for the final value
//   err       out sticky protocol-error flag, cleared by reset or a start
module product_lsb_collector
  import product_lsb_collector_pkg::*;
#(
  parameter int ACC_W = MUL_ACC_W,
  parameter int LSB_W = MUL_LSB_W,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   shift_en,
  input  logic                   d_in,
  input  logic                   acc_final,
  input  logic [ACC_W-1:0]       acc_in,
  output logic [ACC_W+LSB_W-1:0] p_out,
  output logic                   p_valid,
  input  logic                   p_ready,
  output logic                   busy,
  output logic                   err
);

  coll_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [LSB_W-1:0] lsb_reg;
  logic             restart;
  logic             shift_step;

  // A start restarts collection from any state except HOLD; in HOLD it only
  // takes effect when the held product is accepted in the same cycle, so a
  // product waiting for the consumer is never dropped.
  always_comb begin
    restart    = start && ((state != ST_HOLD) || p_ready);
    shift_step = (state == ST_COLLECT) && shift_en && !start;
  end

  lsb_shift_reg #(
    .W(LSB_W)
  ) u_lsb_shift_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (restart),
    .en   (shift_step),
    .d    (d_in),
    .q    (lsb_reg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      p_out   <= '0;
      p_valid <= 1'b0;
      err     <= 1'b0;
    end else if (restart) begin
      state   <= ST_COLLECT;
      cnt     <= '0;
      err     <= 1'b0;
      p_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Stray shift/final strobes between multiplies are harmless.
        end
        ST_COLLECT: begin
          // A final value before all LSBs arrived is flagged and ignored.
          if (acc_final) begin
            err <= 1'b1;
          end
          if (shift_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(LSB_W - 1)) begin
              state <= ST_WAIT_FIN;
            end
          end
        end
        ST_WAIT_FIN: begin
          if (shift_en) begin
            err <= 1'b1;
          end
          if (acc_final) begin
            p_out   <= {acc_in, lsb_reg};
            p_valid <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // start here without p_ready is refused (restart handles the
          // accepted case).
          if (start || shift_en) begin
            err <= 1'b1;
          end
          if (p_ready) begin
            p_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_COLLECT) || (state == ST_WAIT_FIN);

endmodule

// File: tb/tb_product_lsb_collector.sv
module tb_product_lsb_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        shift_en;
  logic        d_in;
  logic        acc_final;
  logic [16:0] acc_in;
  logic [24:0] p_out;
  logic        p_valid;
  logic        p_ready;
  logic        busy;
  logic        err;

  int          n_vec = 0;
  int          n_err = 0;
  int          ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic [24:0] exp_q[$];

  product_lsb_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .shift_en (shift_en),
    .d_in     (d_in),
    .acc_final(acc_final),
    .acc_in   (acc_in),
    .p_out    (p_out),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    d_in   = 1'($urandom);
    acc_in = 17'($urandom);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_shift(input logic b);
    shift_en = 1'b1;
    d_in     = b;
    acc_in   = 17'($urandom);
    tick();
    shift_en = 1'b0;
  endtask

  task automatic do_final(input logic [16:0] acc);
    acc_final = 1'b1;
    acc_in    = acc;
    tick();
    acc_final = 1'b0;
  endtask

  // Expected product: shift i lands at lsb bit i, upper field is acc.
  function automatic logic [24:0] model(input logic [16:0] acc, input logic [7:0] bits);
    return {acc, bits};
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (p_valid && k < 300) begin
      tick();
      k++;
    end
    check("wait_idle_valid", {31'd0, p_valid}, 32'd0);
  endtask

  // p_ready driver
  initial begin
    p_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       p_ready = 1'b0;
        1:       p_ready = 1'b1;
        default: p_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every presented product must match the head of the scoreboard
  // and stay there until accepted.
  always @(negedge clk) begin
    if (rst_n && p_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got p_out %h, expected no product", p_out);
      end else begin
        check("p_out", {7'd0, p_out}, {7'd0, exp_q[0]});
        if (p_ready) begin
          $display("product accepted: %h", p_out);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  bits;
    logic [16:0] acc;
    int          prem;
    bit          exp_err;

    rst_n = 1'b0; start = 1'b0; shift_en = 1'b0; d_in = 1'b0;
    acc_final = 1'b0; acc_in = '0;

    // 1. Reset
    repeat (3) tick();
    check("rst_p_out", {7'd0, p_out}, 32'd0);
    check("rst_p_valid", {31'd0, p_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();
    do_shift(1'b1);
    do_final(17'h1ffff);
    idle_cycle();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_err", {31'd0, err}, 32'd0);
    check("idle_valid", {31'd0, p_valid}, 32'd0);

    // 2. Nominal
    ready_mode = 1;
    bits = 8'b0100_1101;  // shifts 1,0,1,1,0,0,1,0
    do_start();
    check("nom_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) do_shift(bits[i]);
    exp_q.push_back(25'h123454D);
    check("nom_model", {7'd0, model(17'h12345, bits)}, 32'h0123454D);
    do_final(17'h12345);
    check("nom_valid", {31'd0, p_valid}, 32'd1);
    check("nom_err", {31'd0, err}, 32'd0);
    wait_idle();
    $display("nominal done");

    // 3. Back-pressure
    ready_mode = 0;
    tick(); tick();
    do_start();
    for (int i = 0; i < 8; i++) do_shift(bits[i]);
    exp_q.push_back(model(17'h12345, bits));
    do_final(17'h12345);
    repeat (5) idle_cycle();
    do_start();
    check("bp_err", {31'd0, err}, 32'd1);
    check("bp_busy", {31'd0, busy}, 32'd0);
    check("bp_valid", {31'd0, p_valid}, 32'd1);
    ready_mode = 1;
    wait_idle();
    $display("back-pressure done");

    // 4. Gapped shifts with premature final at cnt=3
    bits = 8'hA7;
    do_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        do_final(17'h0F0F0);
        check("gap_err", {31'd0, err}, 32'd1);
        check("gap_busy", {31'd0, busy}, 32'd1);
      end
      repeat (i % 3) idle_cycle();
      do_shift(bits[i]);
    end
    exp_q.push_back(model(17'h1C3A5, bits));
    idle_cycle();
    do_final(17'h1C3A5);
    check("gap_err_sticky", {31'd0, err}, 32'd1);
    wait_idle();
    $display("gapped done");

    // 5. Abort at cnt=5
    do_start();
    for (int i = 0; i < 5; i++) do_shift(1'b0);
    do_start();
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) do_shift(1'b1);
    exp_q.push_back(25'h00000FF);
    do_final(17'h0);
    check("abort_err_end", {31'd0, err}, 32'd0);
    wait_idle();
    $display("abort done");

    // 6. Asynchronous reset mid-collect
    do_start();
    do_shift(1'b1);
    do_final(17'h1);
    do_shift(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_p_out", {7'd0, p_out}, 32'd0);
    check("arst_valid", {31'd0, p_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) idle_cycle();
    check("arst_no_valid", {31'd0, p_valid}, 32'd0);
    $display("async reset done");

    // Randomized transactions with random back-pressure
    ready_mode = 2;
    for (int t = 0; t < 40; t++) begin
      bits = 8'($urandom);
      acc  = 17'($urandom);
      prem = $urandom_range(0, 15);  // < 8: premature final before that shift
      exp_err = 1'b0;
      do_start();
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        if (i == prem) begin
          do_final(17'($urandom));
          exp_err = 1'b1;
        end
        do_shift(bits[i]);
      end
      repeat ($urandom_range(0, 2)) idle_cycle();
      if ($urandom_range(0, 3) == 0) begin
        do_shift(1'($urandom));
        exp_err = 1'b1;
      end
      exp_q.push_back(model(acc, bits));
      do_final(acc);
      check("rnd_err", {31'd0, err}, {31'd0, exp_err});
      $display("txn %0d: bits %h acc %h expected %h err %0d", t, bits, acc, model(acc, bits), exp_err);
      wait_idle();
    end

    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
